prog_loader: RTL and testbench

Program-memory loader for the 8051 core: accepts a framed byte stream over a valid/ready handshake and writes it into code ROM from address 0. It holds the CONTROLLER in reset until a complete frame with a correct checksum has been written. It is the writer side of the code memory that the CONTROLLER fetch path reads. It replaces hard-wired test-program preloading with a real load path.

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the 8051 code memory.
// Accepts LEN_HI, LEN_LO, N code bytes and a checksum byte over a
// valid/ready handshake, writes the code bytes from address 0 and
// releases the CONTROLLER reset only after a frame whose byte sum is zero.
module prog_loader #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   // Longest image the code memory can hold; compared against the 16-bit
   // length field in 17 bits so 2^16 itself is representable.
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          sum_q, sum_d;
   logic [15:0]         count_q, count_d;
   logic [7:0]          lenHi_q, lenHi_d;
   logic                wrEn_q, wrEn_d;
   logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
   logic [7:0]          wrData_q, wrData_d;

   logic                acceptState;
   logic                accept;
   logic [7:0]          sumNext;
   logic [15:0]         lenFull;

   // Handshake decode: ready depends only on state and reset, never on in_valid.
   always_comb begin
      acceptState = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
      in_ready    = acceptState && !rst;
      accept      = in_valid && in_ready;
      sumNext     = sum_q + in_data;
      lenFull     = {lenHi_q, in_data};
   end

   // Next-state logic: reload wins over any byte offered on the same edge.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sum_d    = sum_q;
      count_d  = count_q;
      lenHi_d  = lenHi_q;
      wrEn_d   = 1'b0;
      wrAddr_d = wrAddr_q;
      wrData_d = wrData_q;
      if (reload) begin
         state_d = S_LEN_HI;
         addr_d  = '0;
         sum_d   = '0;
         count_d = '0;
         lenHi_d = '0;
      end else if (accept) begin
         sum_d = sumNext;
         case (state_q)
            S_LEN_HI: begin
               lenHi_d = in_data;
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               if ({1'b0, lenFull} > MAX_LEN) begin
                  state_d = S_ERROR;
               end else if (lenFull == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  count_d = lenFull;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               wrEn_d   = 1'b1;
               wrAddr_d = addr_q;
               wrData_d = in_data;
               addr_d   = addr_q + 1'b1;
               count_d  = count_q - 16'd1;
               if (count_q == 16'd1) begin
                  state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               state_d = (sumNext == 8'h00) ? S_DONE : S_ERROR;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State and write-port registers; reset discards any partial frame at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_LEN_HI;
         addr_q   <= '0;
         sum_q    <= '0;
         count_q  <= '0;
         lenHi_q  <= '0;
         wrEn_q   <= 1'b0;
         wrAddr_q <= '0;
         wrData_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sum_q    <= sum_d;
         count_q  <= count_d;
         lenHi_q  <= lenHi_d;
         wrEn_q   <= wrEn_d;
         wrAddr_q <= wrAddr_d;
         wrData_q <= wrData_d;
      end
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      wr_en   = wrEn_q;
      wr_addr = wrAddr_q;
      wr_data = wrData_q;
      cpu_rst = rst || (state_q != S_DONE);
      busy    = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM);
      done    = (state_q == S_DONE);
      err     = (state_q == S_ERROR);
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scenario tasks for prog_loader with a write scoreboard.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              reload;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;
   int wrCount = 0;

   logic [7:0]          txBytes[$];
   logic [ADDR_W+7:0]   expQ[$];

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Scoreboard: every observed write must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && wr_en === 1'b1) begin
         logic [ADDR_W+7:0] exp;
         wrCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: got addr=%h data=%h, no write expected", wr_addr, wr_data);
         end else begin
            exp = expQ.pop_front();
            if ({wr_addr, wr_data} !== exp) begin
               errors++;
               $display("[TB] FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        wr_addr, wr_data, exp[ADDR_W+7:8], exp[7:0]);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Offer one byte for one edge; optionally follow with an idle cycle of garbage.
   task automatic sendByte(input logic [7:0] b, input bit gap);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      if (gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
   endtask

   // Send txBytes, pushing expected writes for the code-byte positions.
   task automatic sendFrame(input bit throttle);
      int n;
      n = (txBytes.size() >= 2) ? int'({txBytes[0], txBytes[1]}) : 0;
      for (int i = 0; i < txBytes.size(); i++) begin
         if (i >= 2 && i < 2 + n && n <= (1 << ADDR_W)) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(i - 2);
            expQ.push_back({a, txBytes[i]});
         end
         sendByte(txBytes[i], throttle);
      end
      in_valid = 1'b0;
   endtask

   // Pulse reload for one edge.
   task automatic doReload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic loadGood();
      txBytes = '{8'h00, 8'h03, 8'h74, 8'h05, 8'h24, 8'h60};
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
      #3;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err} !==
          {1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_values: got rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b",
                  in_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_good_frame(input bit throttle);
      int w0;
      doReload();
      w0 = wrCount;
      loadGood();
      sendFrame(throttle);
      checks++;
      if ({done, err, cpu_rst, busy, in_ready} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL good_frame_status(thr=%0d): got done=%b err=%b crst=%b busy=%b rdy=%b expected 1 0 0 0 0",
                  throttle, done, err, cpu_rst, busy, in_ready);
      end
      checks++;
      if (wrCount - w0 !== 3 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL good_frame_writes(thr=%0d): got %0d writes, %0d pending, expected 3 and 0",
                  throttle, wrCount - w0, expQ.size());
      end
   endtask

   task automatic test_bad_checksum();
      doReload();
      txBytes = '{8'h00, 8'h03, 8'h74, 8'h05, 8'h24, 8'h61};
      sendFrame(1'b0);
      checks++;
      if ({done, err, cpu_rst, in_ready} !== 4'b0110 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL bad_checksum: got done=%b err=%b crst=%b rdy=%b pending=%0d expected 0 1 1 0 0",
                  done, err, cpu_rst, in_ready, expQ.size());
      end
   endtask

   task automatic test_zero_length();
      int w0;
      doReload();
      w0 = wrCount;
      txBytes = '{8'h00, 8'h00, 8'h00};
      sendFrame(1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || wrCount != w0) begin
         errors++;
         $display("[TB] FAIL zero_len_good: got done=%b err=%b crst=%b writes=%0d expected 1 0 0 0",
                  done, err, cpu_rst, wrCount - w0);
      end
      doReload();
      txBytes = '{8'h00, 8'h00, 8'h01};
      sendFrame(1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b011 || wrCount != w0) begin
         errors++;
         $display("[TB] FAIL zero_len_bad: got done=%b err=%b crst=%b writes=%0d expected 0 1 1 0",
                  done, err, cpu_rst, wrCount - w0);
      end
   endtask

   task automatic test_length_limit();
      int w0;
      int sum;
      doReload();
      w0 = wrCount;
      txBytes = '{8'h10, 8'h01};
      sendFrame(1'b0);
      checks++;
      if ({err, done, busy, in_ready} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL len_over: got err=%b done=%b busy=%b rdy=%b expected 1 0 0 0",
                  err, done, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (wrCount != w0) begin
         errors++;
         $display("[TB] FAIL len_over_writes: got %0d writes expected 0", wrCount - w0);
      end
      doReload();
      txBytes.delete();
      txBytes.push_back(8'h10);
      txBytes.push_back(8'h00);
      sum = 8'h10;
      for (int i = 0; i < 4096; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         txBytes.push_back(b);
         sum += int'(b);
      end
      txBytes.push_back(8'(256 - (sum % 256)));
      sendFrame(1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || expQ.size() != 0 || wrCount - w0 != 4096) begin
         errors++;
         $display("[TB] FAIL len_max: got done=%b err=%b crst=%b pending=%0d writes=%0d expected 1 0 0 0 4096",
                  done, err, cpu_rst, expQ.size(), wrCount - w0);
      end
      checks++;
      if (wr_addr !== 12'hFFF) begin
         errors++;
         $display("[TB] FAIL len_max_last_addr: got %h expected fff", wr_addr);
      end
   endtask

   task automatic test_reload_mid();
      doReload();
      txBytes = '{8'h00, 8'h03, 8'h74};
      sendFrame(1'b0);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h05;
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({busy, cpu_rst, in_ready, wr_en} !== 4'b0110) begin
         errors++;
         $display("[TB] FAIL reload_mid: got busy=%b crst=%b rdy=%b we=%b expected 0 1 1 0",
                  busy, cpu_rst, in_ready, wr_en);
      end
      loadGood();
      sendFrame(1'b0);
      checks++;
      if ({done, err} !== 2'b10 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL reload_restart: got done=%b err=%b pending=%0d expected 1 0 0",
                  done, err, expQ.size());
      end
   endtask

   task automatic test_reload_done();
      checks++;
      if (cpu_rst !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pre_reload_cpu_rst: got %b expected 0", cpu_rst);
      end
      doReload();
      checks++;
      if ({cpu_rst, done, in_ready} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL reload_done: got crst=%b done=%b rdy=%b expected 1 0 1",
                  cpu_rst, done, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      doReload();
      txBytes = '{8'h00, 8'h03, 8'h74, 8'h05};
      sendFrame(1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err} !==
          {1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_mid: got rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b",
                  in_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err);
      end
      @(negedge clk);
      rst = 1'b0;
      loadGood();
      sendFrame(1'b0);
      checks++;
      if ({done, err, cpu_rst} !== 3'b100 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL after_reset_frame: got done=%b err=%b crst=%b pending=%0d expected 1 0 0 0",
                  done, err, cpu_rst, expQ.size());
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      @(negedge clk);
      test_good_frame(1'b0);
      test_bad_checksum();
      test_zero_length();
      test_length_limit();
      test_good_frame(1'b1);
      test_reload_mid();
      test_reload_done();
      test_reset_mid();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
